// File: rtl/fft_pkg.sv
// Shared FFT types and elaboration helpers for the systolic FFT stages.
package fft_pkg;

  localparam int DW_DEFAULT = 16;

  typedef struct packed {
    logic signed [DW_DEFAULT-1:0] re;
    logic signed [DW_DEFAULT-1:0] im;
  } cplx_t;

  // Address width for n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic bit n_points_ok(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/dif_half_ram.sv
// Half-frame sample store: synchronous write, combinational read, no reset.
module dif_half_ram #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [0:DEPTH-1];

  // Store first-half samples as they arrive.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dif_pair_buffer.sv
// DIF stage input buffer: holds the first half-frame and emits x[k], x[k+N/2]
// with twiddle index k while the second half streams in.
module dif_pair_buffer
  import fft_pkg::*;
#(
  parameter int N_POINTS = 8,
  parameter int DW       = DW_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic                              in_sync,
  input  logic [DW-1:0]                     in_re,
  input  logic [DW-1:0]                     in_im,
  output logic                              out_valid,
  output logic [DW-1:0]                     a_re,
  output logic [DW-1:0]                     a_im,
  output logic [DW-1:0]                     b_re,
  output logic [DW-1:0]                     b_im,
  output logic [clog2_min1(N_POINTS/2)-1:0] tw_idx,
  output logic                              out_first,
  output logic                              out_last,
  output logic                              frame_err
);

  localparam int HALF = N_POINTS / 2;
  localparam int AW   = clog2_min1(HALF);
  localparam int CW   = clog2_min1(N_POINTS);

  if (!n_points_ok(N_POINTS)) begin : g_bad_n
    $error("dif_pair_buffer: N_POINTS must be a power of two >= 2");
  end

  logic [CW-1:0]   cnt;
  logic [CW-1:0]   c;
  logic [CW-1:0]   cnt_next;
  logic            is_pair;
  logic            is_first;
  logic            is_last;
  logic            sync_err;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   k;
  logic            wr_en;
  logic [2*DW-1:0] rd_word;

  // Effective sample index and phase decode for the sample on the inputs.
  always_comb begin
    if (in_sync) begin
      c = {CW{1'b0}};
    end else begin
      c = cnt;
    end
    is_pair  = (c >= CW'(HALF));
    is_first = (c == CW'(HALF));
    is_last  = (c == CW'(N_POINTS - 1));
    sync_err = in_sync && (cnt != {CW{1'b0}});
    // N_POINTS is a power of two, so c+1 wraps to 0 after N_POINTS-1.
    cnt_next = c + CW'(1);
    wr_addr  = AW'(c);
    k        = AW'(c - CW'(HALF));
    wr_en    = in_valid && !is_pair;
  end

  dif_half_ram #(
    .DEPTH (HALF),
    .AW    (AW),
    .W     (2 * DW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata ({in_re, in_im}),
    .raddr (k),
    .rdata (rd_word)
  );

  // Counter and registered pair outputs; data holds outside the pair phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= {CW{1'b0}};
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      frame_err <= 1'b0;
      a_re      <= {DW{1'b0}};
      a_im      <= {DW{1'b0}};
      b_re      <= {DW{1'b0}};
      b_im      <= {DW{1'b0}};
      tw_idx    <= {AW{1'b0}};
    end else if (in_valid) begin
      cnt       <= cnt_next;
      frame_err <= sync_err;
      if (is_pair) begin
        out_valid <= 1'b1;
        out_first <= is_first;
        out_last  <= is_last;
        a_re      <= rd_word[2*DW-1:DW];
        a_im      <= rd_word[DW-1:0];
        b_re      <= in_re;
        b_im      <= in_im;
        tw_idx    <= k;
      end else begin
        out_valid <= 1'b0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
      end
    end else begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dif_pair_buffer.sv
// Self-checking bench for dif_pair_buffer against a frame-level reference model.
module tb_dif_pair_buffer;
  import fft_pkg::*;

  localparam int N    = 8;
  localparam int HALF = N / 2;
  localparam int DW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_sync;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_im;
  logic          out_valid;
  logic [DW-1:0] a_re, a_im, b_re, b_im;
  logic [1:0]    tw_idx;
  logic          out_first, out_last, frame_err;

  dif_pair_buffer #(.N_POINTS(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .a_re      (a_re),
    .a_im      (a_im),
    .b_re      (b_re),
    .b_im      (b_im),
    .tw_idx    (tw_idx),
    .out_first (out_first),
    .out_last  (out_last),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pairs  = 0;

  // Reference model: the current frame as an indexed array plus a position.
  logic [DW-1:0] fre [N];
  logic [DW-1:0] fim [N];
  int            pos = 0;
  logic          e_valid, e_first, e_last, e_err;
  logic [DW-1:0] e_a_re, e_a_im, e_b_re, e_b_im;
  int            e_tw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic r,
                      input logic [DW-1:0] re, input logic [DW-1:0] im);
    in_valid = v;
    in_sync  = s;
    rst      = r;
    in_re    = re;
    in_im    = im;
    @(posedge clk);
    if (r) begin
      pos = 0;
      e_valid = 1'b0; e_first = 1'b0; e_last = 1'b0; e_err = 1'b0;
      e_a_re = '0; e_a_im = '0; e_b_re = '0; e_b_im = '0; e_tw = 0;
    end else if (v) begin
      e_err = s && (pos != 0);
      if (s) pos = 0;
      fre[pos] = re;
      fim[pos] = im;
      if (pos >= HALF) begin
        e_valid = 1'b1;
        e_a_re  = fre[pos-HALF];
        e_a_im  = fim[pos-HALF];
        e_b_re  = re;
        e_b_im  = im;
        e_tw    = pos - HALF;
        e_first = (pos == HALF);
        e_last  = (pos == N - 1);
        n_pairs++;
      end else begin
        e_valid = 1'b0; e_first = 1'b0; e_last = 1'b0;
      end
      pos = (pos + 1) % N;
    end else begin
      e_valid = 1'b0; e_first = 1'b0; e_last = 1'b0; e_err = 1'b0;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(e_valid));
    check("out_first", 32'(out_first), 32'(e_first));
    check("out_last",  32'(out_last),  32'(e_last));
    check("frame_err", 32'(frame_err), 32'(e_err));
    check("a_re",      32'(a_re),      32'(e_a_re));
    check("a_im",      32'(a_im),      32'(e_a_im));
    check("b_re",      32'(b_re),      32'(e_b_re));
    check("b_im",      32'(b_im),      32'(e_b_im));
    check("tw_idx",    32'(tw_idx),    32'(e_tw));
  endtask

  // One N-point frame with re = base+i, im = -(base+i); optional gaps and leading sync.
  task automatic send_frame(input int base, input logic sync0, input logic gaps);
    logic [DW-1:0] v;
    for (int i = 0; i < N; i++) begin
      v = DW'(base + i);
      step(1'b1, sync0 && (i == 0), 1'b0, v, -v);
      if (gaps) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    end
  endtask

  initial begin
    cplx_t ext_lo, ext_hi;
    logic [DW-1:0] rr, ri;
    ext_lo = '{re: 16'sh8000, im: 16'sh7FFF};
    ext_hi = '{re: 16'sh7FFF, im: 16'sh8000};

    step(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Basic frame, then the same frame with gaps, then back-to-back A/B.
    send_frame(1, 1'b1, 1'b0);
    check("basic_pairs", 32'(n_pairs), 32'd4);
    send_frame(1, 1'b1, 1'b1);
    send_frame(1, 1'b1, 1'b0);
    send_frame(11, 1'b0, 1'b0);

    // Mid-frame sync: three samples, then a sync'ed frame 9..16.
    for (int i = 0; i < 3; i++) step(1'b1, i == 0, 1'b0, 16'(40 + i), 16'(50 + i));
    send_frame(9, 1'b1, 1'b0);

    // Reset after sample 6 of a frame, then a frame without sync.
    for (int i = 0; i < 6; i++) step(1'b1, i == 0, 1'b0, 16'(31 + i), 16'(61 + i));
    step(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    send_frame(21, 1'b0, 1'b0);

    // Extremes: bit-exact transfer of most negative/positive values.
    for (int i = 0; i < N; i++) begin
      if (i < HALF) step(1'b1, i == 0, 1'b0, ext_lo.re, ext_lo.im);
      else          step(1'b1, 1'b0, 1'b0, ext_hi.re, ext_hi.im);
    end
    check("ext_a_re", 32'(a_re), 32'h8000);
    check("ext_b_im", 32'(b_im), 32'h8000);

    // Randomized traffic: gaps, sparse syncs, rare resets, occasional extremes.
    for (int i = 0; i < 2000; i++) begin
      rr = 16'($urandom);
      ri = 16'($urandom);
      if ($urandom_range(0, 15) == 0) rr = 16'h8000;
      if ($urandom_range(0, 15) == 0) ri = 16'h7FFF;
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 99) == 0,
           rr, ri);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
